// File: rtl/sdp_result_buffer.sv
// Result buffer behind the fixed-latency add/sub pipeline: credit-gated issue,
// latency-aligned valid tracking, and a show-ahead FIFO on a valid/ready port.
module sdp_result_buffer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int IW     = $clog2(LATENCY + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [WIDTH-1:0] pipe_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [CW-1:0]    count,
    output logic [IW-1:0]    inflight,
    output logic             overflow
);

    logic [LATENCY-1:0] v_q, v_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic accept, push, pop, full, push_ok;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + IW'(v_q[i]);
        end
    end

    // Credits come from registered state only, so a pop frees a credit one cycle later.
    assign issue_ready = (32'(count_q) + 32'(inflight)) < DEPTH;
    assign accept      = issue_valid & issue_ready;

    assign res_valid = (count_q != '0);
    assign res_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign push    = v_q[LATENCY-1];
    assign pop     = res_valid & res_ready;
    assign full    = (32'(count_q) == DEPTH);
    assign push_ok = push & (~full | pop);

    always_comb begin
        v_d    = v_q;
        v_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            v_d[i] = v_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped push leaves the FIFO untouched; only the sticky flag records it.
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            v_q        <= v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pipe_out;
        end
    end

endmodule

// File: doc/sdp_result_buffer.md
Name: sdp_result_buffer

Overview:
Downstream consumer of the 3-stage add/sub datapath pipeline (ctl_1/ctl_2/a/b/c -> out, fixed latency 3, no valid/stall).
- Gates upstream issue with credits, so that no result is ever lost.
- Tracks in-flight operations with a valid shift register aligned to the pipeline latency.
- Captures each emerging result into a small FIFO.
- Presents results on a valid/ready interface.

Parameters:
- WIDTH, 8, data width of the pipeline result and res_data.
- DEPTH, 4, result FIFO entries; must be a power of 2, at least 2.
- LATENCY, 3, cycles from an accepted issue to the valid pipeline output; at least 1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  upstream requests to launch one operation into the pipeline this cycle.
- issue_ready  output  1  a credit is available; an issue is accepted when issue_valid && issue_ready.
- pipe_out  input  WIDTH  result bus of the datapath pipeline (its out).
- res_valid  output  1  FIFO head holds a result.
- res_ready  input  1  downstream accepts the head; a pop occurs when res_valid && res_ready.
- res_data  output  WIDTH  FIFO head data; show-ahead.
- count  output  $clog2(DEPTH+1)  number of stored results.
- inflight  output  $clog2(LATENCY+1)  number of accepted issues not yet captured.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (async assert, clears immediately):
  - valid shift register v[LATENCY-1:0] = 0.
  - FIFO pointers = 0; count = 0.
  - overflow = 0; res_valid = 0; issue_ready = 1.
  - res_data is don't-care while res_valid = 0.
- Reset mid-operation:
  - All in-flight and stored results are discarded.
  - The system must hold the datapath pipeline in reset in the same cycles.
  - Any pipe_out value emerging after reset deassertion is ignored, because v = 0.
- Issue tracking, every edge:
  - v[0] <= accepted issue.
  - v[i] <= v[i-1].
  - inflight = popcount(v).
- Capture:
  - A push occurs at an edge when v[LATENCY-1] = 1; pipe_out is written at the tail.
  - Timing: issue accepted at the edge ending cycle t, result written at the edge ending cycle t+LATENCY, res_valid visible in cycle t+LATENCY+1 if the FIFO was empty.
  - Capture is independent of res_ready. There is no backpressure into the pipeline.
- Credit rule:
  - issue_ready = (count + inflight) < DEPTH, computed combinationally from registered state only.
  - A pop in the current cycle does not raise issue_ready until the next cycle (no bypass).
  - When issue_valid = 0 and nothing is accepted, v[0] = 0 and no push occurs LATENCY cycles later.
- FIFO:
  - res_valid = (count != 0); res_data = mem[rd_ptr].
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Pop while empty is impossible (res_valid = 0).
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO, matching issue order.
- Overflow:
  - Push with count == DEPTH and no simultaneous pop: the data is dropped, overflow <= 1 and stays set until reset, and the FIFO state is unchanged.
  - Unreachable when the credit rule is obeyed; it exists as an assertion target.
  - Push with count == DEPTH and a simultaneous pop is legal.
- Arithmetic: results are stored verbatim. Wrap-around has already happened modulo 2^WIDTH upstream.
- Throughput: 1 result per cycle sustained when res_ready is held at 1.

Test Plan:
- Single issue: ctl_1 = 0, ctl_2 = 1, a = 5, b = 3, c = 2, issue_valid for 1 cycle at t -> inflight = 1 for cycles t+1..t+3, res_valid rises in cycle t+4 with res_data = 10, count = 1. A pop drops count to 0.
- Order and arithmetic: back-to-back issues (a,b,c) = (5,3,2) with ctl = (1,0), then (200,100,0) with ctl = (0,0), res_ready = 1 -> res_data sequence 0, 44 (300 mod 256) on consecutive cycles.
- Credit stall: res_ready = 0, issue_valid held at 1 -> exactly 4 issues accepted, issue_ready = 0 from the cycle after the 4th, count reaches 4, overflow stays 0. Raising res_ready for 1 cycle -> issue_ready = 1 the following cycle.
- Full with simultaneous push/pop: count = 3, inflight = 1, res_ready = 1 as the 4th result lands -> count stays at 3, FIFO order preserved, no overflow.
- Forced overflow: force v[LATENCY-1] = 1 with count = 4 and res_ready = 0 -> overflow = 1, count = 4, head data unchanged. overflow remains 1 until reset.
- Async reset mid-flight: 2 in flight and 2 stored, assert reset between edges -> count, inflight and res_valid go to 0 immediately. After release, no spurious push occurs for LATENCY cycles; issue_ready = 1.
